// File: rtl/ram_sync.sv
// ram_sync: synchronous-read unified memory with two independent read ports
// (instruction and data) and one byte-masked write port, all with address
// range/alignment checking.
// Optional feature macro: RAM_SYNC_WR_FWD_EN (write-first collision behaviour;
// read-first when undefined).
module ram_sync #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 16384,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst,
    // instruction read port
    input  logic                    i_ram_ird_req_valid,
    output logic                    o_ram_ird_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_ram_ird_addr,
    output logic                    o_ram_ird_resp_valid,
    input  logic                    i_ram_ird_resp_ready,
    output logic [DATA_WIDTH-1:0]   o_ram_ird_data,
    output logic                    o_ram_ird_err,
    // data read port
    input  logic                    i_ram_drd_req_valid,
    output logic                    o_ram_drd_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_ram_drd_addr,
    output logic                    o_ram_drd_resp_valid,
    input  logic                    i_ram_drd_resp_ready,
    output logic [DATA_WIDTH-1:0]   o_ram_drd_data,
    output logic                    o_ram_drd_err,
    // write port
    input  logic                    i_ram_wr_valid,
    output logic                    o_ram_wr_ready,
    input  logic [ADDR_WIDTH-1:0]   i_ram_wr_addr,
    input  logic [DATA_WIDTH-1:0]   i_ram_wr_data,
    input  logic [DATA_WIDTH/8-1:0] i_ram_wr_mask,
    output logic                    o_ram_wr_err
);

    localparam int unsigned B     = DATA_WIDTH / 8;
    localparam int unsigned LB    = $clog2(B);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam longint unsigned SPAN = 64'(DEPTH) * 64'(B);

    // Reject illegal geometries at elaboration time
    generate
        if ((DATA_WIDTH < 8) || ((DATA_WIDTH & (DATA_WIDTH - 1)) != 0)) begin : g_bad_width
            $error("ram_sync: DATA_WIDTH must be a power of two >= 8");
        end
        if ((ADDR_WIDTH < 64) && (SPAN > (64'd1 << ADDR_WIDTH))) begin : g_bad_span
            $error("ram_sync: DEPTH*B exceeds the byte-address space");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Out of range below/above the array, or not word aligned
    function automatic logic f_bad(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a < BASE_ADDR)
            || ({1'b0, (off >> LB)} >= (ADDR_WIDTH+1)'(DEPTH))
            || ((off & ADDR_WIDTH'(B - 1)) != '0);
    endfunction

    // Word index of a byte address (only meaningful for good addresses)
    function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> LB);
    endfunction

    logic             w_wr_fire;
    logic             w_wr_bad;
    logic             w_wr_do;
    logic [IDX_W-1:0] w_wr_idx;

    assign o_ram_wr_ready = !i_sys_rst;
    assign w_wr_fire      = i_ram_wr_valid && !i_sys_rst;
    assign w_wr_bad       = f_bad(i_ram_wr_addr);
    assign w_wr_do        = w_wr_fire && !w_wr_bad;
    assign w_wr_idx       = f_idx(i_ram_wr_addr);

    // Word seen by a read accepted this cycle; collision policy lives here
    function automatic logic [DATA_WIDTH-1:0] f_rd_word(input logic [IDX_W-1:0] ri);
        logic [DATA_WIDTH-1:0] w;
        w = r_mem[ri];
`ifdef RAM_SYNC_WR_FWD_EN
        if (w_wr_do && (w_wr_idx == ri)) begin
            for (int unsigned b = 0; b < B; b++) begin
                if (i_ram_wr_mask[b]) w[b*8 +: 8] = i_ram_wr_data[b*8 +: 8];
            end
        end
`endif
        return w;
    endfunction

    // Byte-masked array write; no reset so contents survive reset
    always_ff @(posedge i_sys_clk) begin
        if (w_wr_do) begin
            for (int unsigned b = 0; b < B; b++) begin
                if (i_ram_wr_mask[b]) r_mem[w_wr_idx][b*8 +: 8] <= i_ram_wr_data[b*8 +: 8];
            end
        end
    end

    logic r_wr_err;

    // One-cycle error pulse for a write to a bad address
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) r_wr_err <= 1'b0;
        else           r_wr_err <= w_wr_fire && w_wr_bad;
    end

    assign o_ram_wr_err = r_wr_err;

    // ---------------- instruction read port ----------------
    logic                  r_ird_resp_valid;
    logic [DATA_WIDTH-1:0] r_ird_data;
    logic                  r_ird_err;
    logic                  w_ird_req_ready;
    logic                  w_ird_accept;
    logic                  w_ird_bad;
    logic [IDX_W-1:0]      w_ird_idx;

    assign w_ird_req_ready = !i_sys_rst && (!r_ird_resp_valid || i_ram_ird_resp_ready);
    assign w_ird_accept    = i_ram_ird_req_valid && w_ird_req_ready;
    assign w_ird_bad       = f_bad(i_ram_ird_addr);
    assign w_ird_idx       = f_idx(i_ram_ird_addr);

    // Response register with one-entry hold while the consumer stalls
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_ird_resp_valid <= 1'b0;
            r_ird_data       <= '0;
            r_ird_err        <= 1'b0;
        end else if (w_ird_accept) begin
            r_ird_resp_valid <= 1'b1;
            r_ird_err        <= w_ird_bad;
            r_ird_data       <= w_ird_bad ? '0 : f_rd_word(w_ird_idx);
        end else if (i_ram_ird_resp_ready) begin
            r_ird_resp_valid <= 1'b0;
        end
    end

    assign o_ram_ird_req_ready  = w_ird_req_ready;
    assign o_ram_ird_resp_valid = r_ird_resp_valid;
    assign o_ram_ird_data       = r_ird_data;
    assign o_ram_ird_err        = r_ird_err;

    // ---------------- data read port ----------------
    logic                  r_drd_resp_valid;
    logic [DATA_WIDTH-1:0] r_drd_data;
    logic                  r_drd_err;
    logic                  w_drd_req_ready;
    logic                  w_drd_accept;
    logic                  w_drd_bad;
    logic [IDX_W-1:0]      w_drd_idx;

    assign w_drd_req_ready = !i_sys_rst && (!r_drd_resp_valid || i_ram_drd_resp_ready);
    assign w_drd_accept    = i_ram_drd_req_valid && w_drd_req_ready;
    assign w_drd_bad       = f_bad(i_ram_drd_addr);
    assign w_drd_idx       = f_idx(i_ram_drd_addr);

    // Response register with one-entry hold while the consumer stalls
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_drd_resp_valid <= 1'b0;
            r_drd_data       <= '0;
            r_drd_err        <= 1'b0;
        end else if (w_drd_accept) begin
            r_drd_resp_valid <= 1'b1;
            r_drd_err        <= w_drd_bad;
            r_drd_data       <= w_drd_bad ? '0 : f_rd_word(w_drd_idx);
        end else if (i_ram_drd_resp_ready) begin
            r_drd_resp_valid <= 1'b0;
        end
    end

    assign o_ram_drd_req_ready  = w_drd_req_ready;
    assign o_ram_drd_resp_valid = r_drd_resp_valid;
    assign o_ram_drd_data       = r_drd_data;
    assign o_ram_drd_err        = r_drd_err;

endmodule

// File: tb/tb_ram_sync.sv
// Bench for ram_sync: directed scenarios plus randomized traffic checked
// against a word-array reference model.
module tb_ram_sync;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 16384;
    localparam int unsigned B     = DW / 8;
    localparam logic [AW-1:0] BASE = 32'h0;

    logic          clk;
    logic          rst;
    logic          ird_valid, ird_ready, ird_rv, ird_rr, ird_err;
    logic [AW-1:0] ird_addr;
    logic [DW-1:0] ird_data;
    logic          drd_valid, drd_ready, drd_rv, drd_rr, drd_err;
    logic [AW-1:0] drd_addr;
    logic [DW-1:0] drd_data;
    logic          wr_valid, wr_ready, wr_err;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [B-1:0]  wr_mask;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] model [16];

    ram_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .i_sys_clk            (clk),
        .i_sys_rst            (rst),
        .i_ram_ird_req_valid  (ird_valid),
        .o_ram_ird_req_ready  (ird_ready),
        .i_ram_ird_addr       (ird_addr),
        .o_ram_ird_resp_valid (ird_rv),
        .i_ram_ird_resp_ready (ird_rr),
        .o_ram_ird_data       (ird_data),
        .o_ram_ird_err        (ird_err),
        .i_ram_drd_req_valid  (drd_valid),
        .o_ram_drd_req_ready  (drd_ready),
        .i_ram_drd_addr       (drd_addr),
        .o_ram_drd_resp_valid (drd_rv),
        .i_ram_drd_resp_ready (drd_rr),
        .o_ram_drd_data       (drd_data),
        .o_ram_drd_err        (drd_err),
        .i_ram_wr_valid       (wr_valid),
        .o_ram_wr_ready       (wr_ready),
        .i_ram_wr_addr        (wr_addr),
        .i_ram_wr_data        (wr_data),
        .i_ram_wr_mask        (wr_mask),
        .o_ram_wr_err         (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ird_valid = 1'b0; ird_addr = '0; ird_rr = 1'b1;
        drd_valid = 1'b0; drd_addr = '0; drd_rr = 1'b1;
        wr_valid  = 1'b0; wr_addr  = '0; wr_data = '0; wr_mask = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [B-1:0] m);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_drd_req(input logic [AW-1:0] a);
        drd_valid = 1'b1; drd_addr = a; drd_rr = 1'b1;
        tick();
        drd_valid = 1'b0;
    endtask

    // Reference address rule: below base, beyond the array, or misaligned
    function automatic bit m_bad(input logic [AW-1:0] a);
        return (a < BASE) || (((a - BASE) / B) >= DEPTH) || (((a - BASE) % B) != 0);
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        if ({ird_rv, drd_rv, ird_err, drd_err, wr_err, ird_ready, drd_ready, wr_ready} !== 8'h00)
            $display("FAIL reset_flags: got %b exp 00000000",
                     {ird_rv, drd_rv, ird_err, drd_err, wr_err, ird_ready, drd_ready, wr_ready});
        else n_pass++;
        n_total++;
        if ({ird_data, drd_data} !== 64'h0)
            $display("FAIL reset_data: got %h exp 0", {ird_data, drd_data});
        else n_pass++;
        n_total++;
        rst = 1'b0;
        #1;
        if ({ird_ready, drd_ready, wr_ready} !== 3'b111)
            $display("FAIL post_reset_ready: got %b exp 111", {ird_ready, drd_ready, wr_ready});
        else n_pass++;
        n_total++;
        tick();
    endtask

    task automatic test_write_read;
        do_write(BASE + 32'h10, 32'hDEADBEEF, 4'hF);
        do_drd_req(BASE + 32'h10);
        if ({drd_rv, drd_err} !== 2'b10)
            $display("FAIL wr_rd_flags: got v=%b e=%b exp v=1 e=0", drd_rv, drd_err);
        else n_pass++;
        n_total++;
        if (drd_data !== 32'hDEADBEEF)
            $display("FAIL wr_rd_data: got %h exp deadbeef", drd_data);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_byte_mask;
        do_write(BASE + 32'h10, 32'h0000AA00, 4'h2);
        do_drd_req(BASE + 32'h10);
        if (drd_data !== 32'hDEADAAEF)
            $display("FAIL mask_data: got %h exp deadaaef", drd_data);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_hold;
        do_write(BASE + 32'h14, 32'h12345678, 4'hF);
        drd_valid = 1'b1; drd_addr = BASE + 32'h10; drd_rr = 1'b1;
        tick();
        drd_addr = BASE + 32'h14; drd_rr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (drd_ready !== 1'b0)
                $display("FAIL hold_ready[%0d]: got %b exp 0", i, drd_ready);
            else n_pass++;
            n_total++;
            if ({drd_rv, drd_data} !== {1'b1, 32'hDEADAAEF})
                $display("FAIL hold_data[%0d]: got v=%b %h exp v=1 deadaaef", i, drd_rv, drd_data);
            else n_pass++;
            n_total++;
            tick();
        end
        drd_rr = 1'b1;
        #1;
        if (drd_ready !== 1'b1)
            $display("FAIL hold_release_ready: got %b exp 1", drd_ready);
        else n_pass++;
        n_total++;
        tick();
        drd_valid = 1'b0;
        if ({drd_rv, drd_data} !== {1'b1, 32'h12345678})
            $display("FAIL hold_next_data: got v=%b %h exp v=1 12345678", drd_rv, drd_data);
        else n_pass++;
        n_total++;
        tick();
        if (drd_rv !== 1'b0)
            $display("FAIL hold_valid_fall: got %b exp 0", drd_rv);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_collision;
        logic [DW-1:0] exp_d;
`ifdef RAM_SYNC_WR_FWD_EN
        exp_d = 32'h11223344;
`else
        exp_d = 32'hDEADAAEF;
`endif
        ird_valid = 1'b1; ird_addr = BASE + 32'h10; ird_rr = 1'b1;
        wr_valid  = 1'b1; wr_addr  = BASE + 32'h10; wr_data = 32'h11223344; wr_mask = 4'hF;
        tick();
        ird_valid = 1'b0; wr_valid = 1'b0;
        if ({ird_rv, ird_err, ird_data} !== {2'b10, exp_d})
            $display("FAIL collide_data: got v=%b e=%b %h exp v=1 e=0 %h", ird_rv, ird_err, ird_data, exp_d);
        else n_pass++;
        n_total++;
        ird_valid = 1'b1;
        tick();
        ird_valid = 1'b0;
        if (ird_data !== 32'h11223344)
            $display("FAIL collide_after: got %h exp 11223344", ird_data);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_addr_err;
        do_write(BASE, 32'hCAFEF00D, 4'hF);
        do_drd_req(BASE + DEPTH * B);
        if ({drd_rv, drd_err, drd_data} !== {2'b11, 32'h0})
            $display("FAIL err_range: got v=%b e=%b %h exp v=1 e=1 0", drd_rv, drd_err, drd_data);
        else n_pass++;
        n_total++;
        do_drd_req(BASE + 32'h2);
        if ({drd_err, drd_data} !== {1'b1, 32'h0})
            $display("FAIL err_align: got e=%b %h exp e=1 0", drd_err, drd_data);
        else n_pass++;
        n_total++;
        do_write(BASE + DEPTH * B, 32'hFFFFFFFF, 4'hF);
        if (wr_err !== 1'b1)
            $display("FAIL wr_err_pulse: got %b exp 1", wr_err);
        else n_pass++;
        n_total++;
        tick();
        if (wr_err !== 1'b0)
            $display("FAIL wr_err_clear: got %b exp 0", wr_err);
        else n_pass++;
        n_total++;
        do_write(BASE + 32'h10, 32'hFFFFFFFF, 4'h0);
        if (wr_err !== 1'b0)
            $display("FAIL wr_mask0_err: got %b exp 0", wr_err);
        else n_pass++;
        n_total++;
        do_drd_req(BASE);
        if ({drd_err, drd_data} !== {1'b0, 32'hCAFEF00D})
            $display("FAIL bad_wr_alias: got e=%b %h exp e=0 cafef00d", drd_err, drd_data);
        else n_pass++;
        n_total++;
        do_drd_req(BASE + 32'h10);
        if (drd_data !== 32'h11223344)
            $display("FAIL mask0_nochange: got %h exp 11223344", drd_data);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_reset_inflight;
        drd_valid = 1'b1; drd_addr = BASE + 32'h10; drd_rr = 1'b1;
        tick();
        drd_valid = 1'b0; drd_rr = 1'b0;
        if (drd_rv !== 1'b1)
            $display("FAIL rst_pre_valid: got %b exp 1", drd_rv);
        else n_pass++;
        n_total++;
        #2;
        rst = 1'b1;
        #1;
        if ({drd_rv, drd_ready, wr_ready, drd_data} !== {3'b000, 32'h0})
            $display("FAIL rst_async: got v=%b r=%b wr=%b %h exp 0 0 0 0", drd_rv, drd_ready, wr_ready, drd_data);
        else n_pass++;
        n_total++;
        wr_valid = 1'b1; wr_addr = BASE + 32'h10; wr_data = 32'h0; wr_mask = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rst = 1'b0;
        drd_rr = 1'b1;
        tick();
        do_drd_req(BASE + 32'h10);
        if ({drd_rv, drd_data} !== {1'b1, 32'h11223344})
            $display("FAIL rst_retain: got v=%b %h exp v=1 11223344", drd_rv, drd_data);
        else n_pass++;
        n_total++;
    endtask

    function automatic logic [AW-1:0] gen_addr;
        int unsigned r;
        r = $urandom % 10;
        if (r == 0)      return BASE + DEPTH * B + 32'(4 * ($urandom % 4));
        else if (r == 1) return BASE + 32'(4 * ($urandom % 16) + 1 + ($urandom % 3));
        else             return BASE + 32'(4 * ($urandom % 16));
    endfunction

    task automatic test_random;
        logic          ev [2];
        logic [DW-1:0] ed [2];
        logic          ee [2];
        logic          ewe;
        logic          v [2];
        logic          rr [2];
        logic [AW-1:0] a [2];
        logic          gv [2];
        logic [DW-1:0] gd [2];
        logic          ge [2];
        logic          grdy [2];
        logic [DW-1:0] w;
        int unsigned   ix;
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            do_write(BASE + 32'(4 * i), model[i], 4'hF);
        end
        tick();
        ev[0] = 1'b0; ev[1] = 1'b0; ee[0] = 1'b0; ee[1] = 1'b0; ed[0] = '0; ed[1] = '0; ewe = 1'b0;
        for (int c = 0; c < 400; c++) begin
            gv[0] = ird_rv; gd[0] = ird_data; ge[0] = ird_err;
            gv[1] = drd_rv; gd[1] = drd_data; ge[1] = drd_err;
            for (int p = 0; p < 2; p++) begin
                if (gv[p] !== ev[p])
                    $display("FAIL rnd_valid p%0d c%0d: got %b exp %b", p, c, gv[p], ev[p]);
                else n_pass++;
                n_total++;
                if (ev[p]) begin
                    if ({ge[p], gd[p]} !== {ee[p], ed[p]})
                        $display("FAIL rnd_data p%0d c%0d: got e=%b %h exp e=%b %h", p, c, ge[p], gd[p], ee[p], ed[p]);
                    else n_pass++;
                    n_total++;
                end
            end
            if (wr_err !== ewe)
                $display("FAIL rnd_wr_err c%0d: got %b exp %b", c, wr_err, ewe);
            else n_pass++;
            n_total++;
            // new stimulus
            wr_valid = 1'(($urandom % 3) == 0);
            wr_addr  = gen_addr();
            wr_data  = $urandom;
            wr_mask  = 4'($urandom);
            for (int p = 0; p < 2; p++) begin
                v[p]  = 1'($urandom % 2);
                rr[p] = 1'(($urandom % 4) != 0);
                a[p]  = (($urandom % 4) == 0) ? wr_addr : gen_addr();
            end
            ird_valid = v[0]; ird_rr = rr[0]; ird_addr = a[0];
            drd_valid = v[1]; drd_rr = rr[1]; drd_addr = a[1];
            #1;
            grdy[0] = ird_ready; grdy[1] = drd_ready;
            for (int p = 0; p < 2; p++) begin
                if (grdy[p] !== (!ev[p] || rr[p]))
                    $display("FAIL rnd_ready p%0d c%0d: got %b exp %b", p, c, grdy[p], !ev[p] || rr[p]);
                else n_pass++;
                n_total++;
            end
            @(posedge clk);
            // model update for this edge
            for (int p = 0; p < 2; p++) begin
                if (v[p] && (!ev[p] || rr[p])) begin
                    ev[p] = 1'b1;
                    ee[p] = m_bad(a[p]);
                    if (ee[p]) ed[p] = '0;
                    else begin
                        ix = (a[p] - BASE) / B;
                        w  = model[ix];
`ifdef RAM_SYNC_WR_FWD_EN
                        if (wr_valid && !m_bad(wr_addr) && (((wr_addr - BASE) / B) == ix))
                            for (int b = 0; b < 4; b++)
                                if (wr_mask[b]) w[b*8 +: 8] = wr_data[b*8 +: 8];
`endif
                        ed[p] = w;
                    end
                end else if (rr[p]) begin
                    ev[p] = 1'b0;
                end
            end
            ewe = wr_valid && m_bad(wr_addr);
            if (wr_valid && !m_bad(wr_addr)) begin
                ix = (wr_addr - BASE) / B;
                for (int b = 0; b < 4; b++)
                    if (wr_mask[b]) model[ix][b*8 +: 8] = wr_data[b*8 +: 8];
            end
            #1;
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_hold();
        test_collision();
        test_addr_err();
        test_reset_inflight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
